// File: rtl/exe_stage.sv
// Execute stage: one-slot pipeline register around a 12-op ALU with a one-shot data-memory request.
// Optional overflow exception: define EXE_OV_EXC_EN to raise es_ex on signed add/sub overflow.

module alu (
   input  logic [3:0]  alu_op,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   input  logic [4:0]  alu_sa,
   input  logic        alu_imm,
   output logic [31:0] alu_result,
   output logic        alu_overflow
);

   logic [4:0]  shamt;
   logic [31:0] sum;
   logic [31:0] diff;

   // Immediate shifts take the amount from sa, variable shifts from A[4:0]; shifts always act on B.
   assign shamt = alu_imm ? alu_sa : alu_a[4:0];
   assign sum   = alu_a + alu_b;
   assign diff  = alu_a - alu_b;

   always_comb begin
      // NOTE: default every output first so no path through the case infers a latch.
      alu_result   = '0;
      alu_overflow = 1'b0;
      unique case (alu_op)
         4'd0:  alu_result = alu_a & alu_b;
         4'd1:  alu_result = alu_a | alu_b;
         4'd2: begin
            alu_result   = sum;
            alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
         end
         4'd3:  alu_result = alu_b << shamt;
         4'd4:  alu_result = {31'b0, alu_a < alu_b};
         4'd5:  alu_result = {alu_b[15:0], 16'b0};
         4'd6: begin
            alu_result   = diff;
            alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
         end
         4'd7:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
         4'd8:  alu_result = ~(alu_a | alu_b);
         4'd9:  alu_result = alu_a ^ alu_b;
         4'd10: alu_result = alu_b >> shamt;
         4'd11: alu_result = $signed(alu_b) >>> shamt;
         default: alu_result = '0;
      endcase
   end

endmodule

module exe_stage #(
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ds_to_es_valid,
   output logic              es_allowin,
   input  logic [31:0]       ds_pc,
   input  logic [3:0]        ds_alu_op,
   input  logic [31:0]       ds_src1,
   input  logic [31:0]       ds_src2,
   input  logic [4:0]        ds_sa,
   input  logic              ds_imm,
   input  logic [DEST_W-1:0] ds_dest,
   input  logic              ds_gr_we,
   input  logic              ds_mem_we,
   input  logic              ds_res_from_mem,
   input  logic [31:0]       ds_rt_value,
   input  logic              ds_ov_chk,
   input  logic              ms_allowin,
   output logic              es_to_ms_valid,
   output logic [31:0]       es_pc,
   output logic [31:0]       es_result,
   output logic [DEST_W-1:0] es_dest,
   output logic              es_gr_we,
   output logic              es_res_from_mem,
   output logic              es_ex,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_wen,
   output logic [31:0]       data_sram_addr,
   output logic [31:0]       data_sram_wdata,
   input  logic              flush,
   output logic              es_fwd_valid,
   output logic [DEST_W-1:0] es_fwd_dest
);

`ifdef EXE_OV_EXC_EN
   localparam bit OV_EXC_EN = 1'b1;
`else
   localparam bit OV_EXC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0]       pc;
      logic [3:0]        alu_op;
      logic [31:0]       src1;
      logic [31:0]       src2;
      logic [4:0]        sa;
      logic              imm;
      logic [DEST_W-1:0] dest;
      logic              gr_we;
      logic              mem_we;
      logic              res_from_mem;
      logic [31:0]       rt_value;
      logic              ov_chk;
   } ins_t;

   ins_t ds_ins;
   ins_t ins_q, ins_d;
   logic es_valid_q, es_valid_d;
   logic mem_issued_q, mem_issued_d;
   logic es_ready_go;
   logic load;
   logic alu_overflow;

   assign ds_ins = '{pc: ds_pc, alu_op: ds_alu_op, src1: ds_src1, src2: ds_src2,
                     sa: ds_sa, imm: ds_imm, dest: ds_dest, gr_we: ds_gr_we,
                     mem_we: ds_mem_we, res_from_mem: ds_res_from_mem,
                     rt_value: ds_rt_value, ov_chk: ds_ov_chk};

   assign es_ready_go = 1'b1;
   assign es_allowin  = !es_valid_q | (es_ready_go & ms_allowin);
   assign load        = ds_to_es_valid & es_allowin & !flush;

   always_comb begin
      es_valid_d   = es_valid_q;
      ins_d        = ins_q;
      mem_issued_d = mem_issued_q;
      if (flush)           es_valid_d = 1'b0;
      else if (es_allowin) es_valid_d = ds_to_es_valid;
      if (load)            ins_d      = ds_ins;
      // The request is one-shot per resident instruction, so a stall cannot repeat a store.
      if (flush | load)    mem_issued_d = 1'b0;
      else if (es_valid_q) mem_issued_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: every flop here is cleared by reset; there is no storage array that could be left unreset.
      if (reset) begin
         es_valid_q   <= 1'b0;
         mem_issued_q <= 1'b0;
         ins_q        <= '0;
      end else begin
         es_valid_q   <= es_valid_d;
         mem_issued_q <= mem_issued_d;
         ins_q        <= ins_d;
      end
   end

   alu u_alu (
      .alu_op      (ins_q.alu_op),
      .alu_a       (ins_q.src1),
      .alu_b       (ins_q.src2),
      .alu_sa      (ins_q.sa),
      .alu_imm     (ins_q.imm),
      .alu_result  (es_result),
      .alu_overflow(alu_overflow)
   );

   assign es_ex           = OV_EXC_EN & es_valid_q & ins_q.ov_chk & alu_overflow;
   assign es_to_ms_valid  = es_valid_q & es_ready_go;
   assign es_pc           = ins_q.pc;
   assign es_dest         = ins_q.dest;
   assign es_gr_we        = ins_q.gr_we & !es_ex;
   assign es_res_from_mem = ins_q.res_from_mem;

   assign data_sram_en    = es_valid_q & (ins_q.mem_we | ins_q.res_from_mem) & !mem_issued_q & !es_ex;
   assign data_sram_wen   = {4{data_sram_en & ins_q.mem_we}};
   assign data_sram_addr  = es_result;
   assign data_sram_wdata = ins_q.rt_value;

   assign es_fwd_valid    = es_valid_q & es_gr_we;
   assign es_fwd_dest     = ins_q.dest;

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter DEST_W, default 5, destination register index width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ds_to_es_valid  input  1  decode stage presents a valid instruction.
REQ-005 SHALL have port es_allowin  output  1  this stage can accept an instruction this cycle.
REQ-006 SHALL have ports ds_pc (32), ds_alu_op (4), ds_src1 (32), ds_src2 (32), ds_sa (5), ds_imm (1), ds_dest (DEST_W), ds_gr_we (1), ds_mem_we (1), ds_res_from_mem (1), ds_rt_value (32), ds_ov_chk (1), all inputs: decoded instruction fields.
REQ-007 SHALL have port ms_allowin  input  1  memory stage can accept.
REQ-008 SHALL have port es_to_ms_valid  output  1  valid instruction offered to the memory stage.
REQ-009 SHALL have ports es_pc (32), es_result (32), es_dest (DEST_W), es_gr_we (1), es_res_from_mem (1), es_ex (1), all outputs: forwarded instruction fields.
REQ-010 SHALL have ports data_sram_en (1), data_sram_wen (4), data_sram_addr (32), data_sram_wdata (32), all outputs: data memory request.
REQ-011 SHALL have port flush  input  1  discard the resident instruction.
REQ-012 SHALL have ports es_fwd_valid (1) and es_fwd_dest (DEST_W), outputs: hazard info for decode.

Function
REQ-013 SHALL hold a single instruction slot: es_valid register plus latched copies of every ds_* field.
REQ-014 SHALL compute es_ready_go = 1 (single-cycle execute).
REQ-015 SHALL drive es_allowin = !es_valid | (es_ready_go & ms_allowin).
REQ-016 SHALL drive es_to_ms_valid = es_valid & es_ready_go.
REQ-017 SHALL update es_valid: flush -> 0; else if es_allowin -> ds_to_es_valid; else hold.
REQ-018 SHALL latch ds_* fields only when ds_to_es_valid & es_allowin & !flush; otherwise hold.
REQ-019 SHALL instantiate the existing ALU with A=latched src1, B=latched src2, ALUop=latched alu_op, sa, imm; es_result = ALU Result, combinational from latched operands.
REQ-020 SHALL use ALUop encoding 0 and,1 or,2 add,3 sll,4 sltu,5 lui,6 sub,7 slt,8 nor,9 xor,10 srl,11 sra.
REQ-021 SHALL drive data_sram_addr = es_result and data_sram_wdata = latched rt_value.
REQ-022 SHALL keep a one-shot register mem_issued: cleared when a new instruction is latched or on flush, set after the first cycle es_valid is high.
REQ-023 SHALL drive data_sram_en = es_valid & (mem_we | res_from_mem) & !mem_issued & !es_ex, and data_sram_wen = {4{data_sram_en & mem_we}}, so each memory access is issued exactly once even under ms_allowin stall.
REQ-024 SHALL drive es_fwd_valid = es_valid & es_gr_we and es_fwd_dest = latched dest.
REQ-025 SHALL, on flush and ds_to_es_valid in the same cycle, give flush priority: nothing latched, es_valid=0 next cycle.
REQ-026 SHALL, when stalled (es_valid & !ms_allowin), hold all outputs stable except data_sram_en, which drops after its single cycle.

Reset
REQ-027 SHALL, on reset high at a clock edge, clear es_valid, mem_issued and all latched fields to 0; hence es_to_ms_valid, data_sram_en, data_sram_wen, es_gr_we, es_ex, es_fwd_valid read 0 and es_allowin reads 1 in the cycle after.
REQ-028 SHALL give reset priority over flush and latch; reset mid-stall drops the resident instruction.

Configuration
REQ-029 SHALL use macro EXE_OV_EXC_EN: defined -> es_ex = es_valid & latched ov_chk & ALU Overflow, and es_ex forces es_gr_we=0, es_fwd_valid=0 and suppresses the memory request.
REQ-030 SHALL, with EXE_OV_EXC_EN undefined, tie es_ex to 0 and ignore ALU Overflow.

Verification
REQ-031 SHALL cover add: src1=0x7, src2=0x5, alu_op=2, valid, ms_allowin=1 -> next cycle es_to_ms_valid=1, es_result=0x0000000C, es_allowin=1.
REQ-032 SHALL cover store under stall: mem_we=1, src1=0x1000, src2=0x4, alu_op=2, rt_value=0xDEADBEEF, ms_allowin=0 for 3 cycles -> wen=0xF, addr=0x1004 for exactly one cycle; es_allowin=0 throughout stall.
REQ-033 SHALL cover overflow with EXE_OV_EXC_EN: src1=0x7FFFFFFF, src2=0x1, alu_op=2, ov_chk=1 -> es_ex=1, es_gr_we=0; without macro es_ex=0, es_result=0x80000000.
REQ-034 SHALL cover flush with simultaneous ds_to_es_valid=1 -> next cycle es_valid=0, es_to_ms_valid=0, latched fields unchanged.
REQ-035 SHALL cover reset asserted during stall with es_valid=1 -> next cycle all outputs per REQ-027.
REQ-036 SHALL cover back-to-back sra: src2=0x80000000, sa=4, imm=1, alu_op=11, then slt src1=0xFFFFFFFF, src2=0x1, alu_op=7 -> results 0xF8000000 then 0x00000001 on consecutive cycles.
